// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV64 control FSM: states, opcodes,
// ALU control encodings, ALUOp codes, operand/result mux selects.
// Latency: n/a (definitions only). Backpressure: n/a.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } statetype_t;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format is a pure function of the opcode; unknown opcodes get I.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SD:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps (ALUOp, funct3, op[5], funct7b5) to ALUControl plus a
// funct3-supported flag. Latency: combinational. Backpressure: none.
// Ports: alu_op_i, funct3_i, op5_i, funct7b5_i -> alu_control_o, funct3_legal_o.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_control_o,
  output logic       funct3_legal_o
);

  // Only add/sub, or and and are implemented for R/I-type ops.
  assign funct3_legal_o = (funct3_i == 3'b000) || (funct3_i == 3'b110) ||
                          (funct3_i == 3'b111);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // op[5] separates R-type from I-type: addi never subtracts even
          // when instr[30] happens to be set by its immediate.
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control_o = ALU_AND;
          3'b110:  alu_control_o = ALU_OR;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV64 datapath (ld/sd/R/I/beq/jal).
// Latency: selects are Moore outputs of the state; strobes may depend on
// MemReady/Zero in the same cycle. Backpressure: FETCH/MEMREAD/MEMWRITE stall
// on MemReady, bounded by MEM_WAIT_MAX (0 disables the timeout).
// Ports: clk, reset, op/funct3/funct7b5, Zero, MemReady in; ALUControl,
// mux selects, IRWrite/PCWrite/RegWrite/MemWrite, IllegalInstr, MemTimeout out.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [3:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IllegalInstr,
  output logic       MemTimeout
);

  localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  // XLEN does not shape the control logic; only reject nonsensical values.
  if (XLEN <= 0) begin : g_xlen_chk
    $error("multicycle_controller: XLEN must be positive");
  end

  statetype_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] alu_op;
  logic       funct3_legal;
  logic       ir_write, pc_update, branch, reg_write, mem_write, illegal;
  logic       waiting, timeout, strobe_en;

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (ALUControl),
    .funct3_legal_o(funct3_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_op    = ALUOP_ADD;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_FOUR;
    ResultSrc = RES_ALURES;
    AdrSrc    = 1'b0;
    ir_write  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    waiting   = 1'b0;
    case (state_q)
      S_FETCH: begin
        waiting = 1'b1;
        if (MemReady) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed here speculatively into ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        state_d = S_FETCH;
        case (op)
          OP_LD, OP_SD: state_d = S_MEMADR;
          OP_R:   if (funct3_legal) state_d = S_EXECUTER; else illegal = 1'b1;
          OP_I:   if (funct3_legal) state_d = S_EXECUTEI; else illegal = 1'b1;
          OP_BEQ: if (funct3 == 3'b000) state_d = S_BEQ; else illegal = 1'b1;
          OP_JAL: state_d = S_JAL;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_SD) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        waiting   = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_MEMDATA;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        waiting   = 1'b1;
        mem_write = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    // MemReady on the threshold cycle wins: the access completed.
    timeout = waiting && !MemReady && (MEM_WAIT_MAX != 0) &&
              (cnt_q == CNT_W'(MEM_WAIT_MAX - 1));
    if (timeout) state_d = S_FETCH;

    // A timeout in FETCH keeps the state, so it must clear explicitly.
    if (timeout || (state_d != state_q)) cnt_d = '0;
    else if (waiting && !MemReady)      cnt_d = cnt_q + 1'b1;
    else                                cnt_d = cnt_q;
  end

  // Strobes are forced low during reset and on the timeout cycle so that an
  // aborted access never leaves a partial write behind.
  assign strobe_en    = !reset && !timeout;
  assign IRWrite      = ir_write  && strobe_en;
  assign PCWrite      = (pc_update || (branch && Zero)) && strobe_en;
  assign RegWrite     = reg_write && strobe_en;
  assign MemWrite     = mem_write && strobe_en;
  assign IllegalInstr = illegal && !reset;
  assign MemTimeout   = timeout && !reset;
  assign ImmSrc       = imm_src(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: table of per-cycle vectors
// with a scoreboard queue, plus a hand-written mid-MEMWRITE reset sequence.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic [1:0] imm;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       ill;
    logic       to;
  } outs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       mr;
    outs_t      exp;
  } vec_t;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] SD  = 7'b0100011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, MemReady;
  logic [3:0] ALUControl;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, IllegalInstr, MemTimeout;
  outs_t      act;

  int    tests = 0;
  int    fails = 0;
  outs_t sb[$];
  vec_t  vecs[$];

  always #5 clk = ~clk;

  multicycle_controller #(.XLEN(64), .MEM_WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .ALUControl(ALUControl),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .IllegalInstr(IllegalInstr),
    .MemTimeout(MemTimeout)
  );

  assign act = {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
                IRWrite, PCWrite, RegWrite, MemWrite, IllegalInstr, MemTimeout};

  // Expected outputs per state, written from the state/action table.
  function automatic logic [1:0] immf(input logic [6:0] o);
    case (o)
      SD:      return 2'b01;
      BQ:      return 2'b10;
      JL:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic outs_t base(input logic [6:0] o);
    outs_t r = '0;
    r.alu = 4'b0010; r.a = 2'b00; r.b = 2'b10; r.res = 2'b10; r.imm = immf(o);
    return r;
  endfunction

  function automatic outs_t o_fetch(input logic [6:0] o, input logic mr);
    outs_t r = base(o); r.irw = mr; r.pcw = mr; return r;
  endfunction
  function automatic outs_t o_dec(input logic [6:0] o, input logic ill);
    outs_t r = base(o); r.a = 2'b01; r.b = 2'b01; r.ill = ill; return r;
  endfunction
  function automatic outs_t o_madr(input logic [6:0] o);
    outs_t r = base(o); r.a = 2'b10; r.b = 2'b01; return r;
  endfunction
  function automatic outs_t o_mrd(input logic [6:0] o, input logic to);
    outs_t r = base(o); r.adr = 1'b1; r.res = 2'b00; r.to = to; return r;
  endfunction
  function automatic outs_t o_mwb(input logic [6:0] o);
    outs_t r = base(o); r.res = 2'b01; r.rw = 1'b1; return r;
  endfunction
  function automatic outs_t o_mwr(input logic [6:0] o, input logic mw, input logic to);
    outs_t r = base(o); r.adr = 1'b1; r.res = 2'b00; r.mw = mw; r.to = to; return r;
  endfunction
  function automatic outs_t o_ex(input logic [6:0] o, input logic [1:0] srcb,
                                 input logic [3:0] alu);
    outs_t r = base(o); r.a = 2'b10; r.b = srcb; r.alu = alu; return r;
  endfunction
  function automatic outs_t o_awb(input logic [6:0] o);
    outs_t r = base(o); r.res = 2'b00; r.rw = 1'b1; return r;
  endfunction
  function automatic outs_t o_beq(input logic [6:0] o, input logic z);
    outs_t r = base(o);
    r.a = 2'b10; r.b = 2'b00; r.alu = 4'b0110; r.res = 2'b00; r.pcw = z;
    return r;
  endfunction
  function automatic outs_t o_jal(input logic [6:0] o);
    outs_t r = base(o); r.a = 2'b01; r.res = 2'b00; r.pcw = 1'b1; return r;
  endfunction
  function automatic outs_t o_to(input logic [6:0] o);
    outs_t r = base(o); r.to = 1'b1; return r;
  endfunction

  task automatic add_v(input string n, input logic [6:0] o, input logic [2:0] f,
                       input logic f7, input logic z, input logic mr, input outs_t e);
    vec_t t;
    t.name = n; t.op = o; t.f3 = f; t.f7 = f7; t.z = z; t.mr = mr; t.exp = e;
    vecs.push_back(t);
  endtask

  // Full ALU instruction: FETCH, DECODE, EXECUTE*, ALUWB. Zero held high to
  // show it cannot leak into PCWrite outside BEQ.
  task automatic alu_instr(input string n, input logic [6:0] o, input logic [2:0] f,
                           input logic f7, input logic [3:0] alu);
    add_v({n, "/F"}, o, f, f7, 1'b1, 1'b1, o_fetch(o, 1'b1));
    add_v({n, "/D"}, o, f, f7, 1'b1, 1'b1, o_dec(o, 1'b0));
    add_v({n, "/EX"}, o, f, f7, 1'b1, 1'b1, o_ex(o, (o == R) ? 2'b00 : 2'b01, alu));
    add_v({n, "/WB"}, o, f, f7, 1'b1, 1'b1, o_awb(o));
  endtask

  task automatic check(input string n);
    outs_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, got %h", n, act);
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got %b required %b", n, act, e);
      end
    end
  endtask

  // Drive one cycle's inputs (at a negedge), sample 1ns later, move on.
  task automatic step(input vec_t v);
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z; MemReady = v.mr;
    sb.push_back(v.exp);
    #1;
    check(v.name);
    @(negedge clk);
  endtask

  task automatic step_args(input string n, input logic [6:0] o, input logic mr,
                           input outs_t e);
    vec_t t;
    t.name = n; t.op = o; t.f3 = 3'b000; t.f7 = 1'b0; t.z = 1'b0; t.mr = mr; t.exp = e;
    step(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table.
    alu_instr("add", R, 3'b000, 1'b0, 4'b0010);
    alu_instr("sub", R, 3'b000, 1'b1, 4'b0110);
    alu_instr("and", R, 3'b111, 1'b0, 4'b0000);
    alu_instr("or", R, 3'b110, 1'b0, 4'b0001);
    alu_instr("ori", I, 3'b110, 1'b0, 4'b0001);
    alu_instr("andi", I, 3'b111, 1'b0, 4'b0000);
    alu_instr("addi_b30", I, 3'b000, 1'b1, 4'b0010);
    for (int zz = 1; zz >= 0; zz--) begin
      add_v("beq/F", BQ, 3'b000, 1'b0, 1'b0, 1'b1, o_fetch(BQ, 1'b1));
      add_v("beq/D", BQ, 3'b000, 1'b0, 1'b0, 1'b1, o_dec(BQ, 1'b0));
      add_v("beq/BEQ", BQ, 3'b000, 1'b0, zz[0], 1'b1, o_beq(BQ, zz[0]));
    end
    add_v("jal/F", JL, 3'b000, 1'b0, 1'b0, 1'b1, o_fetch(JL, 1'b1));
    add_v("jal/D", JL, 3'b000, 1'b0, 1'b0, 1'b1, o_dec(JL, 1'b0));
    add_v("jal/JAL", JL, 3'b000, 1'b0, 1'b0, 1'b1, o_jal(JL));
    add_v("jal/WB", JL, 3'b000, 1'b0, 1'b0, 1'b1, o_awb(JL));
    // ld with three wait cycles in MEMREAD.
    add_v("ld/F", LD, 3'b011, 1'b0, 1'b0, 1'b1, o_fetch(LD, 1'b1));
    add_v("ld/D", LD, 3'b011, 1'b0, 1'b0, 1'b1, o_dec(LD, 1'b0));
    add_v("ld/MA", LD, 3'b011, 1'b0, 1'b0, 1'b0, o_madr(LD));
    for (int k = 0; k < 3; k++)
      add_v("ld/MR_wait", LD, 3'b011, 1'b0, 1'b0, 1'b0, o_mrd(LD, 1'b0));
    add_v("ld/MR_done", LD, 3'b011, 1'b0, 1'b0, 1'b1, o_mrd(LD, 1'b0));
    add_v("ld/MWB", LD, 3'b011, 1'b0, 1'b0, 1'b0, o_mwb(LD));
    // sd with two wait cycles: MemWrite high for three cycles.
    add_v("sd/F", SD, 3'b011, 1'b0, 1'b0, 1'b1, o_fetch(SD, 1'b1));
    add_v("sd/D", SD, 3'b011, 1'b0, 1'b0, 1'b1, o_dec(SD, 1'b0));
    add_v("sd/MA", SD, 3'b011, 1'b0, 1'b0, 1'b0, o_madr(SD));
    for (int k = 0; k < 2; k++)
      add_v("sd/MW_wait", SD, 3'b011, 1'b0, 1'b0, 1'b0, o_mwr(SD, 1'b1, 1'b0));
    add_v("sd/MW_done", SD, 3'b011, 1'b0, 1'b0, 1'b1, o_mwr(SD, 1'b1, 1'b0));
    // Illegal encodings: pulse in DECODE, then back to FETCH.
    add_v("bad/F", BAD, 3'b000, 1'b0, 1'b0, 1'b1, o_fetch(BAD, 1'b1));
    add_v("bad/D", BAD, 3'b000, 1'b0, 1'b0, 1'b1, o_dec(BAD, 1'b1));
    add_v("rf3/F", R, 3'b001, 1'b0, 1'b0, 1'b1, o_fetch(R, 1'b1));
    add_v("rf3/D", R, 3'b001, 1'b0, 1'b0, 1'b1, o_dec(R, 1'b1));
    add_v("if3/F", I, 3'b100, 1'b0, 1'b0, 1'b1, o_fetch(I, 1'b1));
    add_v("if3/D", I, 3'b100, 1'b0, 1'b0, 1'b1, o_dec(I, 1'b1));
    add_v("bf3/F", BQ, 3'b001, 1'b0, 1'b1, 1'b1, o_fetch(BQ, 1'b1));
    add_v("bf3/D", BQ, 3'b001, 1'b0, 1'b1, 1'b1, o_dec(BQ, 1'b1));
    // FETCH timeout on the 15th wait cycle, then counter restarts from 0:
    // 14 more waits, and MemReady on the 15th counts as success.
    for (int k = 0; k < 14; k++)
      add_v("fto/wait", R, 3'b000, 1'b0, 1'b0, 1'b0, o_fetch(R, 1'b0));
    add_v("fto/timeout", R, 3'b000, 1'b0, 1'b0, 1'b0, o_to(R));
    for (int k = 0; k < 14; k++)
      add_v("fto/rewait", R, 3'b000, 1'b0, 1'b0, 1'b0, o_fetch(R, 1'b0));
    alu_instr("simul", R, 3'b000, 1'b0, 4'b0010);
    // MEMREAD timeout.
    add_v("ldto/F", LD, 3'b011, 1'b0, 1'b0, 1'b1, o_fetch(LD, 1'b1));
    add_v("ldto/D", LD, 3'b011, 1'b0, 1'b0, 1'b1, o_dec(LD, 1'b0));
    add_v("ldto/MA", LD, 3'b011, 1'b0, 1'b0, 1'b0, o_madr(LD));
    for (int k = 0; k < 14; k++)
      add_v("ldto/wait", LD, 3'b011, 1'b0, 1'b0, 1'b0, o_mrd(LD, 1'b0));
    add_v("ldto/timeout", LD, 3'b011, 1'b0, 1'b0, 1'b0, o_mrd(LD, 1'b1));
    // MEMWRITE timeout: MemWrite dropped on the timeout cycle.
    add_v("sdto/F", SD, 3'b011, 1'b0, 1'b0, 1'b1, o_fetch(SD, 1'b1));
    add_v("sdto/D", SD, 3'b011, 1'b0, 1'b0, 1'b1, o_dec(SD, 1'b0));
    add_v("sdto/MA", SD, 3'b011, 1'b0, 1'b0, 1'b0, o_madr(SD));
    for (int k = 0; k < 14; k++)
      add_v("sdto/wait", SD, 3'b011, 1'b0, 1'b0, 1'b0, o_mwr(SD, 1'b1, 1'b0));
    add_v("sdto/timeout", SD, 3'b011, 1'b0, 1'b0, 1'b0, o_mwr(SD, 1'b0, 1'b1));
    alu_instr("after_to", R, 3'b111, 1'b0, 4'b0000);

    // Reset state: strobes low even with MemReady high.
    reset = 1'b1; op = R; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
    sb.push_back(base(R));
    #3;
    check("reset_state");
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    // Reset asserted in the middle of a MEMWRITE wait.
    step_args("rst/F", SD, 1'b1, o_fetch(SD, 1'b1));
    step_args("rst/D", SD, 1'b1, o_dec(SD, 1'b0));
    step_args("rst/MA", SD, 1'b0, o_madr(SD));
    step_args("rst/MW", SD, 1'b0, o_mwr(SD, 1'b1, 1'b0));
    op = SD; MemReady = 1'b0;
    #1;
    sb.push_back(o_mwr(SD, 1'b1, 1'b0));
    check("rst/MW_before");
    #2;
    reset = 1'b1; MemReady = 1'b1;
    #1;
    sb.push_back(base(SD));
    check("rst/async_drop");
    #5;
    sb.push_back(base(SD));
    check("rst/held");
    @(negedge clk);
    reset = 1'b0;
    step_args("rst/post_F", R, 1'b1, o_fetch(R, 1'b1));
    step_args("rst/post_D", R, 1'b1, o_dec(R, 1'b0));
    step_args("rst/post_EX", R, 1'b1, o_ex(R, 2'b00, 4'b0010));
    step_args("rst/post_WB", R, 1'b1, o_awb(R));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
